load_store_unit: RTL and testbench

Load/store unit in the execute stage, directly downstream of the ALU. It takes the effective address produced by the ALU adder (rs1 + imm), runs one data-memory transaction at a time on a req/gnt/rvalid bus, and returns lane-aligned, sign- or zero-extended load data to writeback. It generates byte enables and replicates store data across lanes. It flags misaligned or illegal accesses instead of splitting them.

---
 rtl/load_store_unit.sv | 186 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
//------------------------------------------------------------------------------
// Module   : load_store_unit
// Brief    : Single-outstanding load/store unit on a req/gnt/rvalid data bus,
//            with lane steering, byte enables and load sign/zero extension.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module load_store_unit #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lsu_en_i,
  input  logic                  lsu_we_i,
  input  logic [1:0]            lsu_type_i,
  input  logic                  lsu_sign_ext_i,
  input  logic [WORD_WIDTH-1:0] lsu_addr_i,
  input  logic [WORD_WIDTH-1:0] lsu_wdata_i,
  output logic [WORD_WIDTH-1:0] lsu_rdata_o,
  output logic                  lsu_rvalid_o,
  output logic                  lsu_err_o,
  output logic                  lsu_busy_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic [WORD_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [WORD_WIDTH-1:0] data_wdata_o,
  input  logic [WORD_WIDTH-1:0] data_rdata_i,
  input  logic                  data_rvalid_i
);

  localparam logic [1:0] c_size_byte = 2'b00;
  localparam logic [1:0] c_size_half = 2'b01;
  localparam logic [1:0] c_size_word = 2'b10;
  localparam logic [1:0] c_size_ill  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_REQ         = 2'd1,
    ST_WAIT_RVALID = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic                  r_req;
  logic                  r_we;
  logic [3:0]            r_be;
  logic [WORD_WIDTH-1:0] r_addr;
  logic [WORD_WIDTH-1:0] r_wdata;
  logic [1:0]            r_type;
  logic                  r_sign_ext;
  logic [1:0]            r_off;
  logic                  r_err;
  logic                  r_rvalid;
  logic [WORD_WIDTH-1:0] r_rdata;

  logic                  w_bad;
  logic                  w_accept;
  logic                  w_reject;
  logic                  w_resp;
  logic [3:0]            w_be;
  logic [WORD_WIDTH-1:0] w_wdata;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [WORD_WIDTH-1:0] w_load;

  // Misaligned or illegal sizes are rejected outright, never split.
  always_comb begin
    w_bad = 1'b0;
    case (lsu_type_i)
      c_size_half: w_bad = lsu_addr_i[0];
      c_size_word: w_bad = |lsu_addr_i[1:0];
      c_size_ill:  w_bad = 1'b1;
      default:     w_bad = 1'b0;
    endcase
  end

  assign w_accept = (r_state == ST_IDLE) && lsu_en_i && !w_bad;
  assign w_reject = (r_state == ST_IDLE) && lsu_en_i && w_bad;
  assign w_resp   = (r_state == ST_WAIT_RVALID) && data_rvalid_i;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = lsu_wdata_i;
    case (lsu_type_i)
      c_size_byte: begin
        w_be    = 4'b0001 << lsu_addr_i[1:0];
        w_wdata = {4{lsu_wdata_i[7:0]}};
      end
      c_size_half: begin
        w_be    = 4'b0011 << lsu_addr_i[1:0];
        w_wdata = {2{lsu_wdata_i[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = lsu_wdata_i;
      end
    endcase
  end

  // Lane selection uses the offset latched at accept time, not the live address.
  always_comb begin
    w_byte = data_rdata_i[7:0];
    case (r_off)
      2'd0:    w_byte = data_rdata_i[7:0];
      2'd1:    w_byte = data_rdata_i[15:8];
      2'd2:    w_byte = data_rdata_i[23:16];
      default: w_byte = data_rdata_i[31:24];
    endcase
    w_half = r_off[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    w_load = data_rdata_i;
    case (r_type)
      c_size_byte: w_load = {{(WORD_WIDTH-8){r_sign_ext & w_byte[7]}}, w_byte};
      c_size_half: w_load = {{(WORD_WIDTH-16){r_sign_ext & w_half[15]}}, w_half};
      default:     w_load = data_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:        if (w_accept)      w_state_next = ST_REQ;
      ST_REQ:         if (data_gnt_i)    w_state_next = ST_WAIT_RVALID;
      ST_WAIT_RVALID: if (data_rvalid_i) w_state_next = ST_IDLE;
      default:                           w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_type     <= '0;
      r_sign_ext <= 1'b0;
      r_off      <= '0;
      r_err      <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_err    <= w_reject;
      r_rvalid <= w_resp;
      if (w_accept) begin
        r_req      <= 1'b1;
        r_we       <= lsu_we_i;
        r_be       <= w_be;
        r_addr     <= {lsu_addr_i[WORD_WIDTH-1:2], 2'b00};
        r_wdata    <= w_wdata;
        r_type     <= lsu_type_i;
        r_sign_ext <= lsu_sign_ext_i;
        r_off      <= lsu_addr_i[1:0];
      end else if ((r_state == ST_REQ) && data_gnt_i) begin
        r_req <= 1'b0;
      end
      if (w_resp && !r_we) begin
        r_rdata <= w_load;
      end
    end
  end

  assign lsu_rdata_o  = r_rdata;
  assign lsu_rvalid_o = r_rvalid;
  assign lsu_err_o    = r_err;
  assign lsu_busy_o   = (r_state != ST_IDLE);
  assign data_req_o   = r_req;
  assign data_addr_o  = r_addr;
  assign data_we_o    = r_we;
  assign data_be_o    = r_be;
  assign data_wdata_o = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_load_store_unit
// Brief    : Scoreboard bench for load_store_unit with directed accesses.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_en_i, lsu_we_i, lsu_sign_ext_i;
  logic [1:0]  lsu_type_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic [31:0] lsu_rdata_o;
  logic        lsu_rvalid_o, lsu_err_o, lsu_busy_o;
  logic        data_req_o, data_gnt_i, data_we_o, data_rvalid_i;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic [3:0]  data_be_o;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  load_store_unit #(.WORD_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_en_i(lsu_en_i), .lsu_we_i(lsu_we_i), .lsu_type_i(lsu_type_i),
    .lsu_sign_ext_i(lsu_sign_ext_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_rdata_o(lsu_rdata_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_err_o(lsu_err_o),
    .lsu_busy_o(lsu_busy_o), .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
    .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i), .data_rvalid_i(data_rvalid_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: every completion or error pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (lsu_rvalid_o || lsu_err_o)) begin
      if (q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_response: rvalid=%b err=%b, none expected", lsu_rvalid_o, lsu_err_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_kind", {30'd0, lsu_err_o, lsu_rvalid_o}, e.err ? 32'd2 : 32'd1);
        if (!e.err) chk("resp_rdata", lsu_rdata_o, e.rdata);
      end
    end
  end

  // Issues one access in the current cycle and walks it to completion; returns in
  // the lsu_rvalid_o cycle so the next call is issued back-to-back.
  task automatic access(input logic we, input logic [1:0] typ, input logic sx,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int gnt_wait, input int rv_wait,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rdata, input logic poke);
    logic [31:0] exp_addr;
    exp_addr = {addr[31:2], 2'b00};
    q.push_back('{err: 1'b0, rdata: exp_rdata});
    lsu_en_i = 1'b1; lsu_we_i = we; lsu_type_i = typ; lsu_sign_ext_i = sx;
    lsu_addr_i = addr; lsu_wdata_i = wdata;
    @(posedge clk); #1;
    lsu_en_i = 1'b0; lsu_addr_i = 32'hFFFF_FFFF; lsu_wdata_i = ~wdata;
    for (int k = 0; k <= gnt_wait; k++) begin
      data_gnt_i = (k == gnt_wait);
      lsu_en_i   = poke;
      lsu_type_i = 2'b11;
      @(negedge clk);
      chk("req_high", {31'd0, data_req_o}, 32'd1);
      chk("busy_req", {31'd0, lsu_busy_o}, 32'd1);
      chk("addr", data_addr_o, exp_addr);
      chk("be", {28'd0, data_be_o}, {28'd0, exp_be});
      chk("we", {31'd0, data_we_o}, {31'd0, we});
      if (we) chk("wdata", data_wdata_o, exp_wdata);
      @(posedge clk); #1;
    end
    data_gnt_i = 1'b0;
    for (int k = 0; k <= rv_wait; k++) begin
      data_rvalid_i = (k == rv_wait);
      data_rdata_i  = (k == rv_wait) ? rdata : 32'h5A5A_5A5A;
      lsu_en_i      = poke;
      @(negedge clk);
      chk("req_low_wait", {31'd0, data_req_o}, 32'd0);
      chk("busy_wait", {31'd0, lsu_busy_o}, 32'd1);
      chk("no_early_rvalid", {31'd0, lsu_rvalid_o}, 32'd0);
      @(posedge clk); #1;
    end
    data_rvalid_i = 1'b0;
    lsu_en_i      = 1'b0;
    @(negedge clk);
    chk("rvalid_now", {31'd0, lsu_rvalid_o}, 32'd1);
    chk("busy_done", {31'd0, lsu_busy_o}, 32'd0);
  endtask

  task automatic err_access(input logic [1:0] typ, input logic [31:0] addr);
    q.push_back('{err: 1'b1, rdata: 32'd0});
    lsu_en_i = 1'b1; lsu_we_i = 1'b0; lsu_type_i = typ; lsu_addr_i = addr;
    @(posedge clk); #1;
    lsu_en_i = 1'b0;
    @(negedge clk);
    chk("err_now", {31'd0, lsu_err_o}, 32'd1);
    chk("err_busy", {31'd0, lsu_busy_o}, 32'd0);
    chk("err_req", {31'd0, data_req_o}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("err_single", {31'd0, lsu_err_o}, 32'd0);
    chk("err_no_req", {31'd0, data_req_o}, 32'd0);
    chk("err_busy2", {31'd0, lsu_busy_o}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    lsu_en_i = 0; lsu_we_i = 0; lsu_type_i = 0; lsu_sign_ext_i = 0;
    lsu_addr_i = 0; lsu_wdata_i = 0;
    data_gnt_i = 0; data_rdata_i = 0; data_rvalid_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, data_req_o}, 32'd0);
    chk("rst_busy", {31'd0, lsu_busy_o}, 32'd0);
    chk("rst_rdata", lsu_rdata_o, 32'd0);
    chk("rst_addr", data_addr_o, 32'd0);
    chk("rst_be", {28'd0, data_be_o}, 32'd0);
    chk("rst_flags", {29'd0, lsu_rvalid_o, lsu_err_o, data_we_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    access(0, 2'b10, 0, 32'h1000, 0, 32'hDEADBEEF, 0, 0, 4'b1111, 0, 32'hDEADBEEF, 0);
    access(0, 2'b00, 1, 32'h1003, 0, 32'h80FF0000, 0, 0, 4'b1000, 0, 32'hFFFFFF80, 0);
    access(0, 2'b00, 0, 32'h1003, 0, 32'h80FF0000, 0, 0, 4'b1000, 0, 32'h00000080, 0);
    access(0, 2'b01, 1, 32'h1002, 0, 32'h80FF0000, 0, 0, 4'b1100, 0, 32'hFFFF80FF, 0);
    access(0, 2'b00, 1, 32'h1001, 0, 32'h00007F00, 0, 0, 4'b0010, 0, 32'h0000007F, 0);
    access(1, 2'b01, 0, 32'h2002, 32'h1234ABCD, 32'h77777777, 0, 0, 4'b1100, 32'hABCDABCD, 32'h0000007F, 0);
    access(0, 2'b01, 0, 32'h3000, 0, 32'h1111F00D, 3, 2, 4'b0011, 0, 32'h0000F00D, 1);
    access(1, 2'b00, 0, 32'h3001, 32'h000000A5, 32'h33333333, 1, 1, 4'b0010, 32'hA5A5A5A5, 32'h0000F00D, 1);

    err_access(2'b10, 32'h1002);
    err_access(2'b01, 32'h1001);
    err_access(2'b11, 32'h1000);
    chk("addr_hold", data_addr_o, 32'h3000);
    chk("be_hold", {28'd0, data_be_o}, 32'h2);

    // Abort a load in WAIT_RVALID with an asynchronous reset.
    lsu_en_i = 1'b1; lsu_we_i = 0; lsu_type_i = 2'b10; lsu_addr_i = 32'h4000;
    @(posedge clk); #1;
    lsu_en_i = 1'b0; data_gnt_i = 1'b1;
    @(posedge clk); #1;
    data_gnt_i = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, lsu_busy_o}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, data_req_o}, 32'd0);
    chk("arst_busy", {31'd0, lsu_busy_o}, 32'd0);
    chk("arst_rdata", lsu_rdata_o, 32'd0);
    chk("arst_addr", data_addr_o, 32'd0);
    chk("arst_be", {28'd0, data_be_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFEF00D;
    @(posedge clk); #1;
    data_rvalid_i = 1'b0;
    @(negedge clk);
    chk("stray_rvalid", {31'd0, lsu_rvalid_o}, 32'd0);
    chk("stray_rdata", lsu_rdata_o, 32'd0);
    @(posedge clk); #1;

    access(0, 2'b10, 0, 32'h5004, 0, 32'h01234567, 0, 0, 4'b1111, 0, 32'h01234567, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rvalid_single", {31'd0, lsu_rvalid_o}, 32'd0);
    chk("queue_empty", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
